display_bridge_reader: RTL

- Bridge read responder for the display core; the read-side counterpart of the display register writes.
- Returns config shadows, an ID word, and a per-frame snapshot of video-domain state.
- Video state (square position, frame counter, overrun count) crosses from vid_clk to clk_74a through a toggle request/acknowledge handshake.
- Sits beside the display block. Its read data is OR-muxed into the core's bridge_rd_data.

---
 rtl/display_pkg.sv | 35 +++
 rtl/display_snap_cdc.sv | 112 +++++++++++
 rtl/display_bridge_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display bridge read path: read map, ID constant,
// snapshot field widths and the vid-side handshake states.
package display_pkg;

  localparam logic [31:0] DISPLAY_ID  = 32'h4449_5350;

  localparam logic [31:0] ADDR_ANIM   = 32'h0010_0000;
  localparam logic [31:0] ADDR_DEBUG  = 32'h0010_0004;
  localparam logic [31:0] ADDR_SQX    = 32'h0020_0000;
  localparam logic [31:0] ADDR_SQY    = 32'h0020_0004;
  localparam logic [31:0] ADDR_FRAME  = 32'h0020_0008;
  localparam logic [31:0] ADDR_FSEEN  = 32'h0020_000C;
  localparam logic [31:0] ADDR_TSTAMP = 32'h0020_0010;
  localparam logic [31:0] ADDR_CHEN   = 32'h00F0_000C;
  localparam logic [31:0] ADDR_ID     = 32'h00F0_0020;

  localparam int SQX_W       = 10;
  localparam int SQY_W       = 10;
  localparam int FCNT_W      = 16;
  localparam int OVR_W       = 8;
  localparam int SNAP_DATA_W = SQX_W + SQY_W + FCNT_W;

  typedef struct packed {
    logic [SQX_W-1:0]  sq_x;
    logic [SQY_W-1:0]  sq_y;
    logic [FCNT_W-1:0] frame_count;
    logic [OVR_W-1:0]  overrun;
  } snap_t;

  typedef enum logic [0:0] {
    VID_IDLE = 1'b0,
    VID_BUSY = 1'b1
  } vid_state_e;

endpackage

// File: rtl/display_snap_cdc.sv
// Toggle req/ack crossing of a multi-bit snapshot from vid_clk to clk_74a.
// The vid side owns the hold register and a saturating overrun counter.
module display_snap_cdc
  import display_pkg::*;
#(
  parameter int DATA_W      = SNAP_DATA_W,
  parameter int CNT_W       = OVR_W,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    vid_clk,
  input  logic                    vid_pulse,
  input  logic [DATA_W-1:0]       vid_data,
  output logic [DATA_W+CNT_W-1:0] hold_data,
  output logic                    load
);

  logic [1:0]                 vid_rst_q;
  logic                       vid_rst_n;
  vid_state_e                 state_q, state_d;
  logic                       req_q, req_d;
  logic [DATA_W+CNT_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]           ovr_q, ovr_d;
  logic [SYNC_STAGES-1:0]     ack_sync_q, ack_sync_d;
  logic                       capture, drop;

  logic [SYNC_STAGES-1:0]     req_sync_q, req_sync_d;
  logic                       req_prev_q, req_prev_d;
  logic                       ack_q, ack_d;

  // Vid-domain reset: asserts with reset_n, releases on vid_clk.
  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) vid_rst_q <= 2'b00;
    else          vid_rst_q <= {vid_rst_q[0], 1'b1};
  end
  assign vid_rst_n = vid_rst_q[1];

  // Vid-side state and datapath registers.
  always_ff @(posedge vid_clk or negedge vid_rst_n) begin
    if (!vid_rst_n) begin
      state_q    <= VID_IDLE;
      req_q      <= 1'b0;
      hold_q     <= '0;
      ovr_q      <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      hold_q     <= hold_d;
      ovr_q      <= ovr_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // Vid-side next state: leave BUSY once the returned ack matches req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      VID_IDLE: if (vid_pulse) state_d = VID_BUSY; else state_d = VID_IDLE;
      VID_BUSY: if (ack_sync_q[SYNC_STAGES-1] == req_q) state_d = VID_IDLE;
                else state_d = VID_BUSY;
      default:  state_d = VID_IDLE;
    endcase
  end

  // Vid-side outputs: capture in IDLE, count dropped frames in BUSY.
  always_comb begin
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      VID_IDLE: capture = vid_pulse;
      VID_BUSY: drop    = vid_pulse;
      default:  capture = 1'b0;
    endcase
    if (capture) begin
      req_d  = ~req_q;
      hold_d = {vid_data, ovr_q};
    end else begin
      req_d  = req_q;
      hold_d = hold_q;
    end
    if (drop && (ovr_q != {CNT_W{1'b1}})) ovr_d = ovr_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                  ovr_d = ovr_q;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_q};
  end

  // Bridge-side synchronizer, edge history and ack toggle.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      req_sync_q <= '0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      req_sync_q <= req_sync_d;
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
    end
  end

  // A req edge means hold_q has been stable for the whole sync chain.
  always_comb begin
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_q};
    req_prev_d = req_sync_q[SYNC_STAGES-1];
    load       = req_sync_q[SYNC_STAGES-1] ^ req_prev_q;
    if (load) ack_d = ~ack_q;
    else      ack_d = ack_q;
  end

  assign hold_data = hold_q;

endmodule

// File: rtl/display_bridge_reader.sv
// Bridge read responder for the display core: config shadows, ID and per-frame
// video snapshot. Optional snapshot timestamp under DISPLAY_RD_TIMESTAMP_EN.
module display_bridge_reader
  import display_pkg::*;
#(
  parameter logic [31:0] ID_WORD     = DISPLAY_ID,
  parameter int          SYNC_STAGES = 3
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        vid_clk,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  input  logic        cfg_anim_enable,
  input  logic [2:0]  cfg_channel_enable,
  input  logic [31:0] cfg_debug_value,
  input  logic        vid_frame_pulse,
  input  logic [9:0]  vid_square_x,
  input  logic [9:0]  vid_square_y,
  input  logic [15:0] vid_frame_count,
  output logic        snap_valid
);

  logic [SNAP_DATA_W+OVR_W-1:0] hold_data;
  logic                         snap_load;
  snap_t                        shadow_q, shadow_d;
  logic [31:0]                  fseen_q, fseen_d;
  logic                         snap_valid_q, snap_valid_d;
  logic [31:0]                  rd_data_q, rd_data_d;
  logic [31:0]                  rd_mux;
  logic                         rd_fseen;

  display_snap_cdc #(
    .DATA_W      (SNAP_DATA_W),
    .CNT_W       (OVR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_snap_cdc (
    .clk_74a   (clk_74a),
    .reset_n   (reset_n),
    .vid_clk   (vid_clk),
    .vid_pulse (vid_frame_pulse),
    .vid_data  ({vid_square_x, vid_square_y, vid_frame_count}),
    .hold_data (hold_data),
    .load      (snap_load)
  );

`ifdef DISPLAY_RD_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d, tstamp_q, tstamp_d;

  // Free-running cycle counter, sampled on each snapshot accept.
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
    if (snap_load) tstamp_d = ts_cnt_q;
    else           tstamp_d = tstamp_q;
  end

  // Timestamp registers.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= 32'd0;
      tstamp_q <= 32'd0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      tstamp_q <= tstamp_d;
    end
  end
`endif

  // Shadow update; a coinciding read-to-clear keeps the new frame as 1.
  always_comb begin
    rd_fseen = bridge_rd && (bridge_addr == ADDR_FSEEN);
    if (snap_load) begin
      shadow_d     = snap_t'(hold_data);
      snap_valid_d = 1'b1;
    end else begin
      shadow_d     = shadow_q;
      snap_valid_d = snap_valid_q;
    end
    if (rd_fseen && snap_load) fseen_d = 32'd1;
    else if (rd_fseen)         fseen_d = 32'd0;
    else if (snap_load)        fseen_d = fseen_q + 32'd1;
    else                       fseen_d = fseen_q;
  end

  // Read mux works from pre-update state, so collisions return old values.
  always_comb begin
    rd_mux = 32'd0;
    case (bridge_addr)
      ADDR_ANIM:   rd_mux = {31'd0, cfg_anim_enable};
      ADDR_DEBUG:  rd_mux = cfg_debug_value;
      ADDR_SQX:    rd_mux = {{(32-SQX_W){1'b0}}, shadow_q.sq_x};
      ADDR_SQY:    rd_mux = {{(32-SQY_W){1'b0}}, shadow_q.sq_y};
      ADDR_FRAME:  rd_mux = {shadow_q.overrun, 8'd0, shadow_q.frame_count};
      ADDR_FSEEN:  rd_mux = fseen_q;
      ADDR_CHEN:   rd_mux = {29'd0, cfg_channel_enable};
      ADDR_ID:     rd_mux = ID_WORD;
`ifdef DISPLAY_RD_TIMESTAMP_EN
      ADDR_TSTAMP: rd_mux = tstamp_q;
`endif
      default:     rd_mux = 32'd0;
    endcase
    if (bridge_rd) rd_data_d = rd_mux;
    else           rd_data_d = rd_data_q;
  end

  // Bridge-side registers.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= '0;
      fseen_q      <= 32'd0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      shadow_q     <= shadow_d;
      fseen_q      <= fseen_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bridge_rd_data = rd_data_q;
  assign snap_valid     = snap_valid_q;

endmodule
